// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO and dispatcher that sits directly in front of uart_tx. A
//   producer can write bytes at full clock rate. The FIFO buffers up to
//   2**DEPTH_LOG2 of them and sends them one at a time to uart_tx over its
//   e_i / d_i / busy_o / done_o handshake.
//
//   Build option: define UART_TX_FIFO_OVF_EN to add the sticky ovf_o flag.
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   resetn     asynchronous active-low reset
//   wr_en_i    write strobe; the byte is accepted when full_o is 0
//   wr_d_i     write data
//   full_o     registered: count == DEPTH
//   empty_o    registered: count == 0
//   count_o    number of bytes stored, 0..DEPTH
//   tx_e_o     one-cycle start pulse to uart_tx.e_i
//   tx_d_o     byte to uart_tx.d_i; held from one tx_e_o to the next
//   tx_busy_i  uart_tx.busy_o
//   tx_done_i  uart_tx.done_o, a one-cycle pulse at the end of each frame
//   ovf_o      sticky overflow flag (only with UART_TX_FIFO_OVF_EN)
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr_en_i,
  input  logic [7:0]          wr_d_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LOG2:0] count_o,
  output logic                tx_e_o,
  output logic [7:0]          tx_d_o,
  input  logic                tx_busy_i,
  input  logic                tx_done_i
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic                ovf_o
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t                state_reg, state_next;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp_reg, rp_reg;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic                  full_reg, empty_reg;
  logic                  tx_e_reg;
  logic [7:0]            tx_d_reg;
  logic                  wr_acc;
  logic                  pop;

  // The write is gated by the registered full flag. A pop on the same edge
  // cannot free a slot for this write.
  assign wr_acc = wr_en_i && !full_reg;

  // Dispatcher: it pops only from IDLE. It then waits in WAIT for the frame
  // to finish, so uart_tx never sees a second start while it is busy.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if ((count_reg != '0) && !tx_busy_i) begin
          pop        = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tx_done_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A write and a pop on the same edge cancel out in the count. Both
  // pointers still advance.
  assign count_next = count_reg
                    + (DEPTH_LOG2 + 1)'(wr_acc)
                    - (DEPTH_LOG2 + 1)'(pop);

  // The storage array has no reset because its contents are don't-care
  // until they are written. This lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wp_reg] <= wr_d_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      wp_reg    <= '0;
      rp_reg    <= '0;
      count_reg <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
      tx_e_reg  <= 1'b0;
      tx_d_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      full_reg  <= (count_next == FULL_CNT);
      empty_reg <= (count_next == '0);
      // pop is only ever 1 in IDLE, so the pulse lasts exactly one cycle.
      tx_e_reg  <= pop;
      if (wr_acc) begin
        wp_reg <= wp_reg + PTR_ONE;
      end
      if (pop) begin
        rp_reg   <= rp_reg + PTR_ONE;
        tx_d_reg <= mem[rp_reg];
      end
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_reg;

  // Set by any write attempt while full. It clears only on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_reg <= 1'b0;
    end else if (wr_en_i && full_reg) begin
      ovf_reg <= 1'b1;
    end
  end

  assign ovf_o = ovf_reg;
`endif

  assign full_o  = full_reg;
  assign empty_o = empty_reg;
  assign count_o = count_reg;
  assign tx_e_o  = tx_e_reg;
  assign tx_d_o  = tx_d_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo (DEPTH_LOG2 = 4).
// Stimulus pushes every byte it expects to be transmitted into a scoreboard
// queue. A monitor pops one entry per tx_e_o pulse and compares it with
// tx_d_o. A small uart_tx model (CLKS_PER_BIT = 4, 10-bit frame) drives the
// busy/done handshake.
module tb_uart_tx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int FRAME      = 4 * 10;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic                wr_en = 1'b0;
  logic [7:0]          wr_d = 8'h00;
  logic                full, empty;
  logic [DEPTH_LOG2:0] count;
  logic                tx_e;
  logic [7:0]          tx_d;
  logic                tx_busy;
  logic                tx_done;
  logic                force_busy = 1'b0;
  logic                m_busy = 1'b0;
  logic                m_done = 1'b0;
  int                  m_cnt = 0;
`ifdef UART_TX_FIFO_OVF_EN
  logic                ovf;
`endif

  int       vectors = 0;
  int       miscompares = 0;
  int       tx_seen = 0;
  logic [7:0] sb[$];

  assign tx_busy = force_busy | m_busy;
  assign tx_done = m_done;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .wr_en_i  (wr_en),
    .wr_d_i   (wr_d),
    .full_o   (full),
    .empty_o  (empty),
    .count_o  (count),
    .tx_e_o   (tx_e),
    .tx_d_o   (tx_d),
    .tx_busy_i(tx_busy),
    .tx_done_i(tx_done)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .ovf_o    (ovf)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // uart_tx model. It latches a start at the edge after tx_e is seen, stays
  // busy for one frame, then raises done for one cycle as busy falls.
  initial begin
    forever begin
      @(negedge clk or negedge resetn);
      if (!resetn) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        m_cnt  = 0;
      end else begin
        m_done = 1'b0;
        if (tx_e && !m_busy) begin
          m_busy = 1'b1;
          m_cnt  = FRAME - 1;
        end else if (m_busy) begin
          if (m_cnt == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end else begin
            m_cnt--;
          end
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic prev_e;
    logic [7:0] exp_b;
    prev_e = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_e = 1'b0;
      end else begin
        if (tx_e) begin
          tx_seen++;
          check("tx_e_single_cycle", {31'd0, prev_e}, 32'd0);
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_tx_e: got byte %0h, expected no transmission", tx_d);
          end else begin
            exp_b = sb.pop_front();
            $display("tx byte %02h (expected %02h)", tx_d, exp_b);
            check("tx_d", {24'd0, tx_d}, {24'd0, exp_b});
          end
        end
        prev_e = tx_e;
      end
    end
  end

  // Waits, with a cycle bound, until every expected byte is out and the model
  // is idle.
  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !m_busy) break;
    end
    check(name, sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Writes n consecutive bytes starting at base. Only the first n_push of
  // them are expected on the output.
  task automatic burst(input logic [7:0] base, input int n, input int n_push);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_d  = base + 8'(i);
      if (i < n_push) sb.push_back(wr_d);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    int seen_before;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_full", {31'd0, full}, 0);
    check("rst_empty", {31'd0, empty}, 1);
    check("rst_count", {27'd0, count}, 0);
    check("rst_tx_e", {31'd0, tx_e}, 0);
    check("rst_tx_d", {24'd0, tx_d}, 0);
`ifdef UART_TX_FIFO_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 0);
`endif
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: tx_e follows one cycle after the write edge.
    @(negedge clk);
    wr_en = 1'b1; wr_d = 8'hA5; sb.push_back(8'hA5);
    @(negedge clk);
    wr_en = 1'b0;
    check("single_count1", {27'd0, count}, 1);
    check("single_empty0", {31'd0, empty}, 0);
    check("single_no_early_tx_e", {31'd0, tx_e}, 0);
    @(negedge clk);
    check("single_tx_e", {31'd0, tx_e}, 1);
    check("single_count0", {27'd0, count}, 0);
    check("single_empty1", {31'd0, empty}, 1);
    @(negedge clk);
    check("single_tx_e_low", {31'd0, tx_e}, 0);
    wait_drain("single_drain");

    // Burst 00..0F: the first byte is dispatched at write 2, so 15 remain.
    burst(8'h00, 16, 16);
    check("burst_count", {27'd0, count}, 15);
    check("burst_full", {31'd0, full}, 0);
    wait_drain("burst_drain");
    check("burst_empty", {31'd0, empty}, 1);

    // Overflow: uart_tx held busy, 17 writes, so the 17th byte is dropped.
    force_busy = 1'b1;
    burst(8'h20, 17, 16);
    check("ovf_count", {27'd0, count}, 16);
    check("ovf_full", {31'd0, full}, 1);
    check("ovf_empty", {31'd0, empty}, 0);
    repeat (4) @(negedge clk);
    check("ovf_count_hold", {27'd0, count}, 16);
`ifdef UART_TX_FIFO_OVF_EN
    check("ovf_flag", {31'd0, ovf}, 1);
`endif
    force_busy = 1'b0;
    wait_drain("ovf_drain");
    check("ovf_empty_after", {31'd0, empty}, 1);
`ifdef UART_TX_FIFO_OVF_EN
    check("ovf_sticky", {31'd0, ovf}, 1);
`endif

    // Write and pop on the same edge with count = 3.
    force_busy = 1'b1;
    burst(8'h40, 3, 3);
    check("sim_count3", {27'd0, count}, 3);
    wr_en = 1'b1; wr_d = 8'h43; sb.push_back(8'h43);
    force_busy = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
    check("sim_count_same", {27'd0, count}, 3);
    check("sim_tx_e", {31'd0, tx_e}, 1);
    wait_drain("sim_drain");

    // Wrap-around: 40 bytes in bursts of 10.
    for (int b = 0; b < 4; b++) begin
      burst(8'h50 + 8'(b * 10), 10, 10);
      wait_drain("wrap_drain");
    end

    // Reset mid-frame: 6 writes, first one dispatched, so WAIT with 5 queued.
    burst(8'h80, 6, 6);
    check("mid_count5", {27'd0, count}, 5);
    #2 resetn = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_count", {27'd0, count}, 0);
    check("mid_rst_empty", {31'd0, empty}, 1);
    check("mid_rst_full", {31'd0, full}, 0);
    check("mid_rst_tx_e", {31'd0, tx_e}, 0);
    check("mid_rst_tx_d", {24'd0, tx_d}, 0);
`ifdef UART_TX_FIFO_OVF_EN
    check("mid_rst_ovf", {31'd0, ovf}, 0);
`endif
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    seen_before = tx_seen;
    repeat (60) @(negedge clk);
    check("mid_no_tx_after_rst", tx_seen, seen_before);
    check("mid_count_after", {27'd0, count}, 0);

    // Normal operation after the reset.
    burst(8'h77, 1, 1);
    wait_drain("post_rst_drain");
    check("post_rst_tx_count", tx_seen, seen_before + 1);
    check("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO and dispatcher that sits directly upstream of `uart_tx`. It accepts bytes from a producer at full clock rate, buffers up to DEPTH of them, and hands them one at a time to `uart_tx` over its `e_i`/`d_i`/`busy_o`/`done_o` handshake. Producers such as the loopback path or a command responder can burst bytes without tracking the serializer's state.

## Interface
Parameters:
- `DEPTH_LOG2`, 4: log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 entries of 8 bits.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `wr_en_i`  in  1  write strobe; byte accepted on an edge where `wr_en_i`=1 and `full_o`=0.
- `wr_d_i`  in  8  write data.
- `full_o`  out  1  count == DEPTH (registered).
- `empty_o`  out  1  count == 0 (registered).
- `count_o`  out  DEPTH_LOG2+1  bytes currently stored, 0..DEPTH.
- `tx_e_o`  out  1  one-cycle start pulse to `uart_tx.e_i`.
- `tx_d_o`  out  8  byte to `uart_tx.d_i`; held stable from `tx_e_o` until the next `tx_e_o`.
- `tx_busy_i`  in  1  from `uart_tx.busy_o`.
- `tx_done_i`  in  1  from `uart_tx.done_o`, one-cycle pulse at end of frame.
- `ovf_o`  out  1  sticky overflow flag; present only with `UART_TX_FIFO_OVF_EN`.

## Operation
- Storage: DEPTH x 8 register array, write pointer `wp` and read pointer `rp`, each DEPTH_LOG2 bits, wrapping modulo DEPTH. Occupancy comes from a separate `count` register, so full and empty are distinguished without an extra pointer bit.
- Write: on an edge with `wr_en_i`=1 and `full_o`=0, `mem[wp]`<=`wr_d_i`, `wp`++, `count`++.
- Write while full: byte dropped; pointers and count unchanged. `full_o` is the registered value, so a write is rejected even if a pop happens on the same edge.
- Dispatcher FSM, 2 states:
  - IDLE: if `count`!=0 and `tx_busy_i`=0, on the next edge set `tx_e_o`<=1, `tx_d_o`<=`mem[rp]`, `rp`++, `count`--, and go to WAIT.
  - WAIT: `tx_e_o`<=0. On an edge with `tx_done_i`=1, go to IDLE.
- `tx_done_i` in IDLE is ignored. `tx_busy_i` is only sampled in IDLE.
- Simultaneous accepted write and pop on one edge: `count` unchanged, both pointers advance.
- Pointer wrap: DEPTH-1 wraps to 0; no special handling is needed beyond modulo arithmetic.

## Timing
- Reset values: `full_o`=0, `empty_o`=1, `count_o`=0, `tx_e_o`=0, `tx_d_o`=8'h00, `ovf_o`=0; pointers 0; FSM in IDLE. Array contents are don't-care.
- Reset mid-frame: all of the above apply immediately, asynchronously, and queued bytes are lost. `uart_tx` shares `resetn`, so no stale `tx_done_i` arrives afterward.
- Latency: with FIFO empty, FSM in IDLE and `tx_busy_i`=0, a byte written on edge k produces `tx_e_o`=1 between edges k+1 and k+2.
- `tx_e_o` is never high for two consecutive cycles, and is never asserted while in WAIT.
- Back-to-back bytes: the next `tx_e_o` comes no earlier than 1 cycle after the edge where `tx_done_i` is sampled, and only once `tx_busy_i`=0.
- `empty_o`, `full_o` and `count_o` update on the same edge as the write or pop that changes them.

## Configuration
- `UART_TX_FIFO_OVF_EN` defined:
  - `ovf_o` port exists.
  - `ovf_o` is set on any edge where `wr_en_i`=1 and `full_o`=1.
  - `ovf_o` stays set until `resetn` is asserted.
- `UART_TX_FIFO_OVF_EN` undefined:
  - `ovf_o` port and its register are absent.
  - A write while full is silently dropped.

## Test plan
- Single byte: reset, write 8'hA5 with `tx_busy_i`=0 -> `tx_e_o` pulses 1 cycle later with `tx_d_o`=8'hA5; `count_o` goes 1 -> 0; `empty_o`=1 after the pop.
- Burst with a `uart_tx` model (CLKS_PER_BIT=4): write 8'h00..8'h0F on 16 consecutive cycles with DEPTH=16 -> `full_o`=1 after the 16th write (if none popped yet, otherwise count tracks), and the serial line carries 00..0F in order with no gaps beyond the handshake.
- Overflow: hold `tx_busy_i`=1, write 17 bytes -> `count_o`=16, 17th byte absent from the output stream; with `UART_TX_FIFO_OVF_EN`, `ovf_o`=1 and it stays 1.
- Simultaneous write and pop: with `count_o`=3 in IDLE and `tx_busy_i`=0, write on the dispatch edge -> `count_o` stays 3 and the byte order is preserved.
- Wrap-around: 40 bytes through DEPTH=16 in bursts of 10 -> all 40 are received in order and the pointers wrap twice.
- Reset mid-frame: assert `resetn`=0 while in WAIT with `count_o`=5 -> all outputs take reset values immediately, and after release no `tx_e_o` occurs until a new write.
